// File: rtl/minicpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : minicpu_ctrl_pkg
// Description : Shared encodings for the multicycle MIPS-subset controller:
//               opcodes, funct codes, ALU operation class, FSM state codes
//               and datapath mux selects.
// Revision    : 1.0 - initial release
// ============================================================================
package minicpu_ctrl_pkg;

  // Opcodes of the supported instruction subset
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  // R-type funct codes understood by the ALU decoder
  localparam logic [5:0] c_funct_sll = 6'b000000;
  localparam logic [5:0] c_funct_add = 6'b100000;
  localparam logic [5:0] c_funct_sub = 6'b100010;
  localparam logic [5:0] c_funct_and = 6'b100100;
  localparam logic [5:0] c_funct_or  = 6'b100101;
  localparam logic [5:0] c_funct_slt = 6'b101010;

  // ALU operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    c_alu_op_add   = 2'b00,
    c_alu_op_sub   = 2'b01,
    c_alu_op_funct = 2'b10,
    c_alu_op_rsvd  = 2'b11
  } alu_op_t;

  // FSM state codes
  typedef logic [3:0] ctrl_state_t;
  localparam ctrl_state_t c_st_fetch     = 4'd0;
  localparam ctrl_state_t c_st_decode    = 4'd1;
  localparam ctrl_state_t c_st_memadr    = 4'd2;
  localparam ctrl_state_t c_st_memrd     = 4'd3;
  localparam ctrl_state_t c_st_memwb     = 4'd4;
  localparam ctrl_state_t c_st_memwr     = 4'd5;
  localparam ctrl_state_t c_st_execute   = 4'd6;
  localparam ctrl_state_t c_st_aluwb     = 4'd7;
  localparam ctrl_state_t c_st_branch    = 4'd8;
  localparam ctrl_state_t c_st_addiexec  = 4'd9;
  localparam ctrl_state_t c_st_addiwb    = 4'd10;
  localparam ctrl_state_t c_st_jump      = 4'd11;
  localparam ctrl_state_t c_st_branch_ne = 4'd12;

  // ALU operand B select
  localparam logic [1:0] c_srcb_b       = 2'b00;
  localparam logic [1:0] c_srcb_four    = 2'b01;
  localparam logic [1:0] c_srcb_imm     = 2'b10;
  localparam logic [1:0] c_srcb_imm_sh2 = 2'b11;

  // PC source select
  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Interface   : multicycle_control_unit_if
// Description : Instruction fields, memory handshake and datapath control
//               bundle between the multicycle controller (master) and the
//               datapath/memory side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if #(
  parameter int OP_W       = 6,
  parameter int FUNCT_W    = 6,
  parameter int ALU_CTRL_W = 3
);
  logic [OP_W-1:0]       op;
  logic [FUNCT_W-1:0]    funct;
  logic                  mem_ready;
  logic                  mem_req;
  logic                  mem_write;
  logic                  iord;
  logic                  ir_write;
  logic                  pc_write;
  logic                  branch;
  logic                  branch_ne;
  logic [1:0]            pc_src;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic                  reg_dst;
  logic                  mem_to_reg;
  logic                  reg_write;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  illegal_op;
  logic                  mem_timeout;

  modport master (
    input  op, funct, mem_ready,
    output mem_req, mem_write, iord, ir_write, pc_write, branch, branch_ne,
           pc_src, alu_src_a, alu_src_b, reg_dst, mem_to_reg, reg_write,
           alu_control, illegal_op, mem_timeout
  );

  modport slave (
    output op, funct, mem_ready,
    input  mem_req, mem_write, iord, ir_write, pc_write, branch, branch_ne,
           pc_src, alu_src_a, alu_src_b, reg_dst, mem_to_reg, reg_write,
           alu_control, illegal_op, mem_timeout
  );
endinterface
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps the FSM's ALU operation class and the R-type funct field
//               to the ALU control code.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
  import minicpu_ctrl_pkg::*;
#(
  parameter int FUNCT_W    = 6,
  parameter int ALU_CTRL_W = 3
) (
  input  alu_op_t               alu_op,
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  // Address/branch arithmetic is fixed; R-type picks the operation from funct
  always_comb begin
    alu_control = ALU_CTRL_W'(3'b010);
    case (alu_op)
      c_alu_op_add: alu_control = ALU_CTRL_W'(3'b010);
      c_alu_op_sub: alu_control = ALU_CTRL_W'(3'b110);
      c_alu_op_funct: begin
        case (funct)
          c_funct_add: alu_control = ALU_CTRL_W'(3'b010);
          c_funct_sub: alu_control = ALU_CTRL_W'(3'b110);
          c_funct_and: alu_control = ALU_CTRL_W'(3'b000);
          c_funct_or:  alu_control = ALU_CTRL_W'(3'b001);
          c_funct_slt: alu_control = ALU_CTRL_W'(3'b111);
          c_funct_sll: alu_control = ALU_CTRL_W'(3'b011);
          default:     alu_control = ALU_CTRL_W'(3'b010);
        endcase
      end
      default: alu_control = ALU_CTRL_W'(3'b010);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Multicycle MIPS-subset controller. Steps each instruction
//               through fetch/decode/execute/memory/writeback over a shared
//               datapath, with a mem_ready handshake guarded by a wait
//               timeout and one-cycle illegal-opcode / timeout pulses.
//               Optional macro BNE_EN adds bne via a BRANCH_NE state.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
  import minicpu_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int FUNCT_W     = 6,
  parameter int ALU_CTRL_W  = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_unit_if.master bus
);

  // Wait counter only needs to reach MEM_TIMEOUT-1
  localparam int c_cnt_w = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  ctrl_state_t          r_state;
  ctrl_state_t          w_next_state;
  logic [c_cnt_w-1:0]   r_wait_cnt;
  logic                 r_illegal_op;
  logic                 r_mem_timeout;
  logic                 w_mem_state;
  logic                 w_timeout;
  logic                 w_illegal;
  logic [OP_W-1:0]      w_op;
  alu_op_t              w_alu_op;

  assign w_op = bus.op;

  assign w_mem_state = (r_state == c_st_fetch) ||
                       (r_state == c_st_memrd) ||
                       (r_state == c_st_memwr);

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      // Last permitted wait cycle with no completion; mem_ready always wins
      assign w_timeout = w_mem_state && !bus.mem_ready &&
                         (r_wait_cnt == c_cnt_w'(MEM_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  // Next-state selection; a timeout abandons the instruction back to FETCH
  always_comb begin
    w_next_state = r_state;
    w_illegal    = 1'b0;
    case (r_state)
      c_st_fetch:  if (bus.mem_ready) w_next_state = c_st_decode;
      c_st_decode: begin
        case (w_op)
          c_op_lw, c_op_sw: w_next_state = c_st_memadr;
          c_op_rtype:       w_next_state = c_st_execute;
          c_op_beq:         w_next_state = c_st_branch;
          c_op_addi:        w_next_state = c_st_addiexec;
          c_op_j:           w_next_state = c_st_jump;
`ifdef BNE_EN
          c_op_bne:         w_next_state = c_st_branch_ne;
`endif
          default: begin
            w_next_state = c_st_fetch;
            w_illegal    = 1'b1;
          end
        endcase
      end
      c_st_memadr:    w_next_state = (w_op == c_op_lw) ? c_st_memrd : c_st_memwr;
      c_st_memrd:     if (bus.mem_ready) w_next_state = c_st_memwb;
      c_st_memwb:     w_next_state = c_st_fetch;
      c_st_memwr:     if (bus.mem_ready) w_next_state = c_st_fetch;
      c_st_execute:   w_next_state = c_st_aluwb;
      c_st_aluwb:     w_next_state = c_st_fetch;
      c_st_branch:    w_next_state = c_st_fetch;
      c_st_branch_ne: w_next_state = c_st_fetch;
      c_st_addiexec:  w_next_state = c_st_addiwb;
      c_st_addiwb:    w_next_state = c_st_fetch;
      c_st_jump:      w_next_state = c_st_fetch;
      default:        w_next_state = c_st_fetch;
    endcase
    if (w_timeout) w_next_state = c_st_fetch;
  end

  // State register and the registered one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_st_fetch;
      r_illegal_op  <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_illegal_op  <= w_illegal;
      r_mem_timeout <= w_timeout;
    end
  end

  // Count consecutive stalled cycles in a memory state; clear otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_mem_state && !bus.mem_ready && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign bus.illegal_op  = r_illegal_op;
  assign bus.mem_timeout = r_mem_timeout;

  // Datapath controls decoded from the current state
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.branch     = 1'b0;
    bus.branch_ne  = 1'b0;
    bus.pc_src     = c_pcsrc_alu;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = c_srcb_b;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    w_alu_op       = c_alu_op_add;
    case (r_state)
      c_st_fetch: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = c_srcb_four;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      c_st_decode: bus.alu_src_b = c_srcb_imm_sh2;
      c_st_memadr: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = c_srcb_imm;
      end
      c_st_memrd: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
      end
      c_st_memwb: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
      end
      c_st_memwr: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      c_st_execute: begin
        w_alu_op      = c_alu_op_funct;
        bus.alu_src_a = 1'b1;
        // sll takes its shift amount through the immediate path
        bus.alu_src_b = (bus.funct == FUNCT_W'(c_funct_sll)) ? c_srcb_imm : c_srcb_b;
      end
      c_st_aluwb: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
      end
      c_st_branch: begin
        bus.alu_src_a = 1'b1;
        w_alu_op      = c_alu_op_sub;
        bus.pc_src    = c_pcsrc_aluout;
        bus.branch    = 1'b1;
      end
`ifdef BNE_EN
      c_st_branch_ne: begin
        bus.alu_src_a = 1'b1;
        w_alu_op      = c_alu_op_sub;
        bus.pc_src    = c_pcsrc_aluout;
        bus.branch_ne = 1'b1;
      end
`endif
      c_st_addiexec: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = c_srcb_imm;
      end
      c_st_addiwb: bus.reg_write = 1'b1;
      c_st_jump: begin
        bus.pc_src   = c_pcsrc_jump;
        bus.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder #(
    .FUNCT_W    (FUNCT_W),
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_decoder (
    .alu_op      (w_alu_op),
    .funct       (bus.funct),
    .alu_control (bus.alu_control)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Self-checking bench for multicycle_control_unit. A phase-queue
//               model expands each decoded instruction into its sequence of
//               control steps; directed sequences pin the model with literal
//               expectations, then randomized instructions and memory stalls
//               follow. Honours BNE_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OP_W(6), .FUNCT_W(6), .ALU_CTRL_W(3)) bus ();

  multicycle_control_unit #(
    .OP_W(6), .FUNCT_W(6), .ALU_CTRL_W(3), .MEM_TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXEC,
    P_ALUWB, P_BR, P_BRNE, P_ADDIEX, P_ADDIWB, P_JUMP
  } phase_e;

  phase_e q[$];
  int     waited;
  bit     exp_ill, exp_to, fresh;
  int     total = 0;
  int     bad   = 0;
  int     pct   = 100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] alu_ref(input logic [1:0] aop, input logic [5:0] f);
    if (aop == 2'b01) return 3'b110;
    if (aop != 2'b10) return 3'b010;
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      6'h00:   return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  // Expected control word for one step of an instruction
  function automatic logic [17:0] exp_vec(input phase_e p, input logic rdy, input logic [5:0] f);
    logic mreq, mw, io, irw, pcw, br, brne, a, rd, m2r, rw;
    logic [1:0] ps, b, aop;
    {mreq, mw, io, irw, pcw, br, brne, a, rd, m2r, rw} = '0;
    ps = 2'b00; b = 2'b00; aop = 2'b00;
    case (p)
      P_FETCH:  begin mreq = 1; b = 2'b01; irw = rdy; pcw = rdy; end
      P_DECODE: b = 2'b11;
      P_MEMADR: begin a = 1; b = 2'b10; end
      P_MEMRD:  begin mreq = 1; io = 1; end
      P_MEMWB:  begin m2r = 1; rw = 1; end
      P_MEMWR:  begin mreq = 1; mw = 1; io = 1; end
      P_EXEC:   begin aop = 2'b10; a = 1; b = (f == 6'd0) ? 2'b10 : 2'b00; end
      P_ALUWB:  begin rd = 1; rw = 1; end
      P_BR:     begin a = 1; aop = 2'b01; ps = 2'b01; br = 1; end
      P_BRNE:   begin a = 1; aop = 2'b01; ps = 2'b01; brne = 1; end
      P_ADDIEX: begin a = 1; b = 2'b10; end
      P_ADDIWB: rw = 1;
      P_JUMP:   begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {mreq, mw, io, irw, pcw, br, brne, ps, a, b, rd, m2r, rw, alu_ref(aop, f)};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
            bus.branch, bus.branch_ne, bus.pc_src, bus.alu_src_a, bus.alu_src_b,
            bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_control};
  endfunction

  function automatic bit is_mem(input phase_e p);
    return (p == P_FETCH) || (p == P_MEMRD) || (p == P_MEMWR);
  endfunction

  task automatic model_reset();
    q.delete();
    q.push_back(P_FETCH);
    waited  = 0;
    exp_ill = 0;
    exp_to  = 0;
    fresh   = 1;
  endtask

  // Advance the model by one clock using the inputs the DUT saw at the edge
  task automatic model_advance();
    phase_e p;
    p = q[0];
    exp_ill = 0;
    exp_to  = 0;
    if (is_mem(p)) begin
      if (bus.mem_ready) begin
        void'(q.pop_front());
        waited = 0;
        if (p == P_FETCH) q.push_back(P_DECODE);
      end else if (TO > 0 && waited == TO - 1) begin
        q.delete();
        waited = 0;
        exp_to = 1;
      end else begin
        waited++;
      end
    end else begin
      void'(q.pop_front());
      if (p == P_DECODE) begin
        case (bus.op)
          6'b100011: begin q.push_back(P_MEMADR); q.push_back(P_MEMRD); q.push_back(P_MEMWB); end
          6'b101011: begin q.push_back(P_MEMADR); q.push_back(P_MEMWR); end
          6'b000000: begin q.push_back(P_EXEC); q.push_back(P_ALUWB); end
          6'b000100: q.push_back(P_BR);
          6'b001000: begin q.push_back(P_ADDIEX); q.push_back(P_ADDIWB); end
          6'b000010: q.push_back(P_JUMP);
`ifdef BNE_EN
          6'b000101: q.push_back(P_BRNE);
`endif
          default: exp_ill = 1;
        endcase
      end
    end
    if (q.size() == 0) begin
      q.push_back(P_FETCH);
      fresh = 1;
    end
  endtask

  task automatic check_all();
    chk("outputs", 32'(dut_vec()), 32'(exp_vec(q[0], bus.mem_ready, bus.funct)));
    chk("illegal_op", 32'(bus.illegal_op), 32'(exp_ill));
    chk("mem_timeout", 32'(bus.mem_timeout), 32'(exp_to));
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
    chk("rst_fetch_ctrl", 32'({bus.mem_req, bus.iord, bus.alu_src_b}), 32'b1001);
    chk("rst_pulses", 32'({bus.illegal_op, bus.mem_timeout}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.op        = 6'd0;
    bus.funct     = 6'h20;
    bus.mem_ready = 1'b1;
    do_reset();

    // add: FETCH, DECODE, EXECUTE, ALUWB, back in FETCH at cycle 4
    bus.op = 6'b000000; bus.funct = 6'h20; bus.mem_ready = 1'b1;
    cycle(); chk("add_decode_srcb", 32'(bus.alu_src_b), 32'b11);
    cycle(); chk("add_exec_aluctl", 32'({bus.alu_control, bus.alu_src_b}), 32'b01000);
    cycle(); chk("add_aluwb", 32'({bus.reg_write, bus.reg_dst}), 32'b11);
    cycle(); chk("add_back_fetch", 32'({bus.mem_req, bus.iord}), 32'b10);

    // lw with three stall cycles in MEMRD: 8 cycles total
    bus.op = 6'b100011;
    cycle(); cycle(); cycle();
    bus.mem_ready = 1'b0;
    cycle(); cycle(); cycle();
    chk("lw_memrd_held", 32'({bus.mem_req, bus.iord}), 32'b11);
    bus.mem_ready = 1'b1;
    cycle(); chk("lw_memwb", 32'({bus.mem_to_reg, bus.reg_write, bus.reg_dst}), 32'b110);
    cycle(); chk("lw_back_fetch", 32'({bus.mem_req, bus.iord}), 32'b10);

    // sw that never completes: 4 cycles in MEMWR, then timeout pulse
    bus.op = 6'b101011;
    cycle(); cycle(); cycle();
    bus.mem_ready = 1'b0;
    cycle(); cycle(); cycle();
    chk("sw_memwr_held", 32'(bus.mem_write), 32'd1);
    cycle();
    chk("sw_timeout_pulse", 32'({bus.mem_timeout, bus.mem_write, bus.mem_req}), 32'b101);
    bus.mem_ready = 1'b1;
    cycle(); chk("sw_timeout_width", 32'(bus.mem_timeout), 32'd0);
    bus.op = 6'b000010;
    cycle(); chk("jump_ctrl", 32'({bus.pc_write, bus.pc_src}), 32'b110);
    cycle();

    // illegal opcode: DECODE then FETCH with a single-cycle pulse
    bus.op = 6'b111111;
    cycle();
    cycle(); chk("ill_pulse", 32'(bus.illegal_op), 32'd1);
    bus.op = 6'b000010;
    cycle(); chk("ill_pulse_width", 32'(bus.illegal_op), 32'd0);
    cycle(); cycle();

    // bne
    bus.op = 6'b000101;
    cycle(); cycle();
`ifdef BNE_EN
    chk("bne_branch_ne", 32'({bus.branch_ne, bus.branch, bus.pc_src}), 32'b1001);
    cycle();
`else
    chk("bne_illegal", 32'({bus.illegal_op, bus.branch_ne}), 32'b10);
`endif

    // asynchronous reset while in MEMWB
    bus.op = 6'b100011; bus.mem_ready = 1'b1;
    cycle(); cycle(); cycle(); cycle();
    chk("pre_rst_memwb", 32'(bus.reg_write), 32'd1);
    do_reset();
    cycle();

    // randomized instruction stream with random memory stalls
    for (int n = 0; n < 3000; n++) begin
      if (fresh) begin
        fresh = 0;
        case ($urandom_range(0, 8))
          0: bus.op = 6'b100011;
          1: bus.op = 6'b101011;
          2: bus.op = 6'b000000;
          3: bus.op = 6'b000100;
          4: bus.op = 6'b000101;
          5: bus.op = 6'b001000;
          6: bus.op = 6'b000010;
          7: bus.op = 6'b111111;
          default: bus.op = 6'($urandom);
        endcase
        case ($urandom_range(0, 6))
          0: bus.funct = 6'h20;
          1: bus.funct = 6'h22;
          2: bus.funct = 6'h24;
          3: bus.funct = 6'h25;
          4: bus.funct = 6'h2a;
          5: bus.funct = 6'h00;
          default: bus.funct = 6'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0: pct = 0;
          1: pct = 60;
          default: pct = 100;
        endcase
      end
      bus.mem_ready = ($urandom_range(0, 99) < pct);
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle MIPS-subset controller. Sequences each instruction through fetch/decode/execute/memory/writeback states over a shared datapath and a single unified memory.
- Adds a memory ready handshake with a parametrised timeout, plus illegal-opcode reporting.
- Drives datapath muxes and enables, and reuses the existing alu_decoder for alu_control.

Parameters:
- OP_W, 6, opcode field width.
- FUNCT_W, 6, funct field width.
- ALU_CTRL_W, 3, alu_control width.
- MEM_TIMEOUT, 16, max wait cycles for mem_ready in any memory state; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- op  in  OP_W  instruction opcode (from IR).
- funct  in  FUNCT_W  instruction funct (from IR).
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  write strobe (valid with mem_req).
- iord  out  1  address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- branch  out  1  conditional PC load on zero.
- branch_ne  out  1  conditional PC load on not-zero.
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- alu_src_a  out  1  0=PC, 1=register A.
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-extended imm, 11=imm<<2.
- reg_dst  out  1  1=rd, 0=rt.
- mem_to_reg  out  1  1=memory data, 0=ALUOut.
- reg_write  out  1  register file write.
- alu_control  out  ALU_CTRL_W  from alu_decoder.
- illegal_op  out  1  one-cycle pulse, unsupported opcode.
- mem_timeout  out  1  one-cycle pulse, memory wait expired.

Behaviour:
- Reset (rst_n=0, asynchronous): state=FETCH, wait counter=0, illegal_op=0, mem_timeout=0. All outputs take their FETCH values.
- State register and counter update on the clk rising edge. Outputs are combinational from state. Only ir_write and pc_write in FETCH also depend on mem_ready.
- Outputs not listed for a state are 0. alu_op defaults to 00.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01.
  - ir_write=pc_write=mem_ready.
  - Go to DECODE on mem_ready; otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11. Next state by op:
  - lw/sw -> MEMADR.
  - R-type -> EXECUTE.
  - beq -> BRANCH.
  - addi -> ADDIEXEC.
  - j -> JUMP.
  - any other opcode -> FETCH, with illegal_op pulsed on the following cycle (registered).
- MEMADR: alu_src_a=1, alu_src_b=10. Go to MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, iord=1. Go to MEMWB on mem_ready.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Go to FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Go to FETCH on mem_ready.
- EXECUTE:
  - alu_op=10.
  - funct==0 (sll): alu_src_a=1, alu_src_b=10.
  - Otherwise: alu_src_a=1, alu_src_b=00.
  - Go to ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. Go to FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10. Go to ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Go to FETCH.
- JUMP: pc_src=10, pc_write=1. Go to FETCH.
- Latency: R-type/addi 4 cycles, lw 5, sw 4, beq/j 3, assuming zero-wait memory.
- Wait counter:
  - Increments each cycle in FETCH/MEMRD/MEMWR while mem_ready=0.
  - Clears on any state change or when mem_ready=1.
- Timeout (MEM_TIMEOUT>0): if counter==MEM_TIMEOUT-1 and mem_ready=0, go to FETCH and pulse mem_timeout next cycle. No register or PC write occurs. A FETCH timeout refetches the same PC.
- mem_ready on the timeout cycle: mem_ready wins and is treated as normal completion.
- mem_ready outside memory states is ignored.
- Reset asserted mid-instruction: immediate return to FETCH; no pulses.

Optional Feature:
- Macro BNE_EN.
- Defined: op 000101 (bne) in DECODE goes to BRANCH_NE. BRANCH_NE has the same outputs as BRANCH except branch=0 and branch_ne=1.
- Undefined: bne is an illegal opcode, and branch_ne is tied to 0.

Decomposition:
- Package minicpu_ctrl_pkg holds:
  - opcode localparams (R-type, lw, sw, beq, bne, addi, j);
  - the alu_op_t typedef (2-bit);
  - the state enum ctrl_state_t;
  - alu_src_b and pc_src encodings.
- Sub-module: the existing alu_decoder (alu_op, funct -> alu_control), instantiated once.
- The FSM and timeout counter stay in this module.

Test Plan:
- Reset, then add (op 000000, funct 100000) with mem_ready=1 always -> FETCH, DECODE, EXECUTE (alu_op 10), ALUWB (reg_write=1, reg_dst=1), back in FETCH at cycle 4.
- lw with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with mem_to_reg=1; total 8 cycles.
- MEM_TIMEOUT=4, sw with mem_ready=0 -> MEMWR for 4 cycles, then FETCH, mem_timeout=1 for exactly 1 cycle, reg_write never asserted.
- op 111111 -> DECODE then FETCH, illegal_op pulse of 1 cycle, no pc_write outside FETCH.
- bne (000101) -> with BNE_EN: BRANCH_NE with branch_ne=1, pc_src=01. Without BNE_EN: illegal_op pulse.
- rst_n deasserted-to-asserted during MEMWB -> next observed state FETCH, reg_write=0 immediately (asynchronous).
